// File: rtl/apb_regfile_pkg.sv
// Shared types and constants for the APB3 to 16x8 register-file bridge.
package apb_regfile_pkg;

    localparam int PADDR_W     = 8;
    localparam int PDATA_W     = 32;
    localparam int REG_COUNT   = 16;
    localparam int DATA_W      = 8;
    localparam int RF_AW       = $clog2(REG_COUNT);
    localparam int RF_ADDR_LSB = 2;
    localparam int CNT_W       = 3;

    // Any set bit under this mask marks a misaligned (non-word) access.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RDWAIT,
        ACK
    } state_t;

    // An address is illegal if it is misaligned or has any bit set above addr_msb.
    function automatic logic addr_illegal(input logic [PADDR_W-1:0] paddr,
                                          input int                 addr_msb);
        logic [PADDR_W-1:0] hi_mask;
        hi_mask = {PADDR_W{1'b1}} << (addr_msb + 1);
        return ((paddr[1:0] & ALIGN_MASK) != 2'b00) || ((paddr & hi_mask) != '0);
    endfunction

endpackage

// File: rtl/apb_regfile_bridge.sv
// APB3 slave that turns transfers into one-cycle strobes for an external 16x8 register file.
// Latency: write PREADY 2 cycles after setup edge, read RD_LATENCY+2, decode error 1.
// Backpressure: PREADY held low (wait states) until the access finishes; PSEL drop aborts.
module apb_regfile_bridge
    import apb_regfile_pkg::*;
#(
    parameter int RD_LATENCY = 2,
    parameter int ADDR_MSB   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               PSEL,
    input  logic               PENABLE,
    input  logic               PWRITE,
    input  logic [PADDR_W-1:0] PADDR,
    input  logic [PDATA_W-1:0] PWDATA,
    output logic [PDATA_W-1:0] PRDATA,
    output logic               PREADY,
    output logic               PSLVERR,
    output logic               rf_wr_en,
    output logic               rf_rd_en,
    output logic [RF_AW-1:0]   rf_addr,
    output logic [DATA_W-1:0]  rf_data_in,
    input  logic [DATA_W-1:0]  rf_data_out
);

    state_t             state;
    logic [CNT_W-1:0]   rd_cnt;
    logic [DATA_W-1:0]  prdata_q;

    logic unused_pwdata;
    assign unused_pwdata = ^PWDATA[PDATA_W-1:DATA_W];

    assign PRDATA = {{(PDATA_W-DATA_W){1'b0}}, prdata_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rd_cnt     <= '0;
            prdata_q   <= '0;
            PREADY     <= 1'b0;
            PSLVERR    <= 1'b0;
            rf_wr_en   <= 1'b0;
            rf_rd_en   <= 1'b0;
            rf_addr    <= '0;
            rf_data_in <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (PSEL && !PENABLE) begin
                        if (addr_illegal(PADDR, ADDR_MSB)) begin
                            state   <= ACK;
                            PREADY  <= 1'b1;
                            PSLVERR <= 1'b1;
                        end else begin
                            // rf_addr/rf_data_in only move on legal accesses so they hold otherwise
                            rf_addr <= PADDR[RF_ADDR_LSB +: RF_AW];
                            if (PWRITE) begin
                                state      <= WR;
                                rf_wr_en   <= 1'b1;
                                rf_data_in <= PWDATA[DATA_W-1:0];
                            end else begin
                                state    <= RD;
                                rf_rd_en <= 1'b1;
                            end
                        end
                    end
                end
                WR: begin
                    rf_wr_en <= 1'b0;
                    if (!PSEL) begin
                        state <= IDLE;
                    end else begin
                        state  <= ACK;
                        PREADY <= 1'b1;
                    end
                end
                RD: begin
                    rf_rd_en <= 1'b0;
                    if (!PSEL) begin
                        state <= IDLE;
                    end else begin
                        state  <= RDWAIT;
                        rd_cnt <= CNT_W'(RD_LATENCY);
                    end
                end
                RDWAIT: begin
                    if (!PSEL) begin
                        state  <= IDLE;
                        rd_cnt <= '0;
                    end else begin
                        rd_cnt <= rd_cnt - CNT_W'(1);
                        // Counter reaching zero on this edge lines up with valid rf_data_out
                        if (rd_cnt == CNT_W'(1)) begin
                            prdata_q <= rf_data_out;
                            state    <= ACK;
                            PREADY   <= 1'b1;
                        end
                    end
                end
                ACK: begin
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_regfile_bridge.sv
// Scoreboard bench: three bridges (RD_LATENCY 2, 1, 3), each with a registered 16x8 register-file model.
module tb_apb_regfile_bridge;

    typedef struct {
        int          inst;
        int          cyc;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    typedef struct {
        int          inst;
        int          cyc;
        logic        wr;
        logic [3:0]  addr;
        logic [7:0]  data;
    } strb_t;

    logic             clk;
    logic             reset;
    logic [2:0]       psel, penable, pwrite, pready, pslverr, rf_wr_en, rf_rd_en;
    logic [2:0][7:0]  paddr, rf_data_in, rf_data_out, last_rd, last_wr;
    logic [2:0][31:0] pwdata, prdata;
    logic [2:0][3:0]  rf_addr;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    resp_t resp_q[$];
    strb_t strb_q[$];
    resp_t mon_r;
    strb_t mon_s;

    logic [7:0] tbl [16] = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h80, 8'h3C, 8'hC3,
                             8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
        logic [7:0] mem  [16];
        logic [7:0] pipe [L];

        apb_regfile_bridge #(.RD_LATENCY(L), .ADDR_MSB(5)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .PSEL       (psel[g]),
            .PENABLE    (penable[g]),
            .PWRITE     (pwrite[g]),
            .PADDR      (paddr[g]),
            .PWDATA     (pwdata[g]),
            .PRDATA     (prdata[g]),
            .PREADY     (pready[g]),
            .PSLVERR    (pslverr[g]),
            .rf_wr_en   (rf_wr_en[g]),
            .rf_rd_en   (rf_rd_en[g]),
            .rf_addr    (rf_addr[g]),
            .rf_data_in (rf_data_in[g]),
            .rf_data_out(rf_data_out[g])
        );

        // Data is valid only in the one cycle L-1 edges after the sampling edge; 0xEE otherwise.
        always @(posedge clk) begin
            if (rf_wr_en[g]) mem[rf_addr[g]] <= rf_data_in[g];
            pipe[0] <= rf_rd_en[g] ? mem[rf_addr[g]] : 8'hEE;
            for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
        end
        assign rf_data_out[g] = pipe[L-1];
    end

    function automatic int lat_of(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %0h expected %0h", name, i, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            chk({tag, "_prdata"}, i, prdata[i], 32'h0);
            chk({tag, "_pready"}, i, 32'(pready[i]), 32'h0);
            chk({tag, "_pslverr"}, i, 32'(pslverr[i]), 32'h0);
            chk({tag, "_wr_en"}, i, 32'(rf_wr_en[i]), 32'h0);
            chk({tag, "_rd_en"}, i, 32'(rf_rd_en[i]), 32'h0);
            chk({tag, "_rf_addr"}, i, 32'(rf_addr[i]), 32'h0);
            chk({tag, "_rf_data_in"}, i, 32'(rf_data_in[i]), 32'h0);
        end
    endtask

    // Response monitor: every PREADY must match the oldest expected response.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (pready[i]) begin
                if (resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pready inst%0d: got PREADY=1 at cycle %0d expected none", i, cyc);
                end else begin
                    mon_r = resp_q.pop_front();
                    chk("resp_inst", i, 32'(i), 32'(mon_r.inst));
                    chk("resp_cycle", i, 32'(cyc), 32'(mon_r.cyc));
                    chk("resp_pslverr", i, 32'(pslverr[i]), 32'(mon_r.err));
                    chk("resp_prdata", i, prdata[i], mon_r.rdata);
                end
            end
        end
    end

    // Strobe monitor: every rf strobe cycle must match the oldest expected strobe.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rf_wr_en[i] || rf_rd_en[i]) begin
                chk("strobe_exclusive", i, 32'(rf_wr_en[i] & rf_rd_en[i]), 32'h0);
                if (strb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe inst%0d: got wr=%0b rd=%0b at cycle %0d expected none",
                             i, rf_wr_en[i], rf_rd_en[i], cyc);
                end else begin
                    mon_s = strb_q.pop_front();
                    chk("strobe_inst", i, 32'(i), 32'(mon_s.inst));
                    chk("strobe_cycle", i, 32'(cyc), 32'(mon_s.cyc));
                    chk("strobe_is_wr", i, 32'(rf_wr_en[i]), 32'(mon_s.wr));
                    chk("strobe_addr", i, 32'(rf_addr[i]), 32'(mon_s.addr));
                    chk("strobe_data_in", i, 32'(rf_data_in[i]), 32'(mon_s.data));
                end
            end
        end
    end

    task automatic apb_setup(input int i, input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
        psel[i]    = 1'b1;
        penable[i] = 1'b0;
        pwrite[i]  = wr;
        paddr[i]   = addr;
        pwdata[i]  = {24'hC3C3C3, wdata};
    endtask

    task automatic push_strobe(input int i, input logic wr, input logic [3:0] ra, input logic [7:0] wdata);
        strb_t s;
        s.inst = i;
        s.cyc  = cyc;
        s.wr   = wr;
        s.addr = ra;
        s.data = wr ? wdata : last_wr[i];
        strb_q.push_back(s);
        if (wr) last_wr[i] = wdata;
    endtask

    task automatic apb_xfer(input int i, input logic wr, input logic [7:0] addr, input logic [3:0] exp_ra,
                            input logic [7:0] wdata, input logic exp_err, input logic [7:0] exp_rdata);
        resp_t r;
        int    lat;
        logic  done;
        apb_setup(i, wr, addr, wdata);
        @(posedge clk); #1;
        lat     = exp_err ? 1 : (wr ? 2 : lat_of(i) + 2);
        r.inst  = i;
        r.cyc   = cyc + lat - 1;
        r.err   = exp_err;
        r.rdata = {24'h0, (wr || exp_err) ? last_rd[i] : exp_rdata};
        resp_q.push_back(r);
        if (!exp_err) push_strobe(i, wr, exp_ra, wdata);
        penable[i] = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (pready[i]) begin
                done = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL pready_timeout inst%0d: got no PREADY within 12 cycles expected one", i);
        end
        @(posedge clk); #1;
        psel[i]    = 1'b0;
        penable[i] = 1'b0;
        if (!exp_err && !wr) last_rd[i] = exp_rdata;
    endtask

    task automatic apb_rd_abort(input int i, input logic [7:0] addr, input logic [3:0] exp_ra);
        apb_setup(i, 1'b0, addr, 8'h00);
        @(posedge clk); #1;
        push_strobe(i, 1'b0, exp_ra, 8'h00);
        penable[i] = 1'b1;
        @(posedge clk); #1;
        psel[i]    = 1'b0;
        penable[i] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("abort_no_pready", i, 32'(pready[i]), 32'h0);
        end
    endtask

    task automatic apb_reset_abort(input int i, input logic wr, input logic [7:0] addr, input logic [3:0] exp_ra,
                                   input logic [7:0] wdata, input int n_access);
        apb_setup(i, wr, addr, wdata);
        @(posedge clk); #1;
        push_strobe(i, wr, exp_ra, wdata);
        penable[i] = 1'b1;
        repeat (n_access - 1) begin
            @(posedge clk); #1;
        end
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        chk_all_zero("reset_mid");
        psel[i]    = 1'b0;
        penable[i] = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset   = 1'b0;
        last_rd = '0;
        last_wr = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish within 100000 time units expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        psel    = '0;
        penable = '0;
        pwrite  = '0;
        paddr   = '0;
        pwdata  = '0;
        last_rd = '0;
        last_wr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic write, write then readback, decode errors
        apb_xfer(0, 1'b1, 8'h0C, 4'd3, 8'hA5, 1'b0, 8'h00);
        apb_xfer(0, 1'b1, 8'h1C, 4'd7, 8'h5A, 1'b0, 8'h00);
        apb_xfer(0, 1'b0, 8'h1C, 4'd7, 8'h00, 1'b0, 8'h5A);
        apb_xfer(0, 1'b0, 8'h41, 4'd0, 8'h00, 1'b1, 8'h00);
        apb_xfer(0, 1'b1, 8'h80, 4'd0, 8'h33, 1'b1, 8'h00);
        apb_xfer(0, 1'b0, 8'h0C, 4'd3, 8'h00, 1'b0, 8'hA5);

        // PSEL drop in RDWAIT, then a normal read
        apb_rd_abort(0, 8'h1C, 4'd7);
        apb_xfer(0, 1'b0, 8'h1C, 4'd7, 8'h00, 1'b0, 8'h5A);

        // Reset during WR and during RDWAIT, then reg 15 traffic
        apb_reset_abort(0, 1'b1, 8'h3C, 4'd15, 8'h77, 1);
        apb_reset_abort(0, 1'b0, 8'h0C, 4'd3, 8'h00, 2);
        apb_xfer(0, 1'b1, 8'h3C, 4'd15, 8'hFF, 1'b0, 8'h00);
        apb_xfer(0, 1'b0, 8'h3C, 4'd15, 8'h00, 1'b0, 8'hFF);
        apb_xfer(0, 1'b0, 8'h0C, 4'd3, 8'h00, 1'b0, 8'hA5);

        // Full register sweep on the latency-1 and latency-3 bridges
        for (int i = 1; i < 3; i++) begin
            for (int r = 0; r < 16; r++)
                apb_xfer(i, 1'b1, 8'(r * 4), 4'(r), tbl[(r + i) % 16], 1'b0, 8'h00);
            for (int r = 0; r < 16; r++)
                apb_xfer(i, 1'b0, 8'(r * 4), 4'(r), 8'h00, 1'b0, tbl[(r + i) % 16]);
        end

        repeat (5) @(posedge clk);
        #1;
        chk("resp_q_drained", 0, 32'(resp_q.size()), 32'h0);
        chk("strb_q_drained", 0, 32'(strb_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_regfile_bridge.md
APB_REGFILE_BRIDGE -- requirements
Module: apb_regfile_bridge

Interface
REQ-001 Parameter RD_LATENCY, default 2: clock edges from the sampled rd_en edge to valid rf_data_out; legal range 1..7.
REQ-002 Parameter ADDR_MSB, default 5: highest decoded PADDR bit; PADDR[ADDR_MSB:2] selects 1 of 16 registers.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 PSEL  input  1  APB3 slave select.
REQ-006 PENABLE  input  1  APB3 access phase.
REQ-007 PWRITE  input  1  1 = write, 0 = read.
REQ-008 PADDR  input  8  byte address.
REQ-009 PWDATA  input  32  write data; only bits [7:0] are used.
REQ-010 PRDATA  output  32  read data; bits [31:8] are always 0.
REQ-011 PREADY  output  1  transfer complete.
REQ-012 PSLVERR  output  1  error response; valid only while PREADY=1.
REQ-013 rf_wr_en  output  1  one-cycle register-file write strobe.
REQ-014 rf_rd_en  output  1  one-cycle register-file read strobe.
REQ-015 rf_addr  output  4  register-file address.
REQ-016 rf_data_in  output  8  register-file write data.
REQ-017 rf_data_out  input  8  register-file read data; registered, RD_LATENCY edges after the rf_rd_en edge.

Function
REQ-018 All outputs SHALL be registered.
REQ-019 FSM states SHALL be IDLE, WR, RD, RDWAIT, ACK.
REQ-020 IDLE: on PSEL=1 and PENABLE=0 (setup phase), latch PADDR, PWRITE and PWDATA[7:0].
REQ-021 Setup-phase branch: illegal address goes to ACK with PSLVERR=1; otherwise PWRITE=1 goes to WR and PWRITE=0 goes to RD.
REQ-022 An address is illegal if PADDR[1:0]!=0 or PADDR[7:ADDR_MSB+1]!=0; an illegal access SHALL generate no rf strobe.
REQ-023 WR: rf_wr_en=1 for exactly one cycle, with rf_addr=PADDR[5:2] and rf_data_in=PWDATA[7:0]; next state is ACK.
REQ-024 RD: rf_rd_en=1 for exactly one cycle with rf_addr set; next state is RDWAIT, and a 3-bit counter loads RD_LATENCY.
REQ-025 RDWAIT: decrement the counter each cycle; at 0, capture rf_data_out into PRDATA[7:0] and go to ACK.
REQ-026 ACK: PREADY=1 for exactly one cycle, then return to IDLE; PREADY, PSLVERR and rf strobes are 0 in every other state.
REQ-027 Write latency: PREADY is high in the 2nd cycle after the setup edge (one wait state).
REQ-028 Read latency with RD_LATENCY=2: PREADY is high in the 4th cycle after the setup edge (three wait states).
REQ-029 PRDATA SHALL hold its value until the next read capture; writes and errors do not change it.
REQ-030 If PSEL falls in WR, RD or RDWAIT (protocol abort), the FSM SHALL return to IDLE next edge with no PREADY. A strobe already issued is not retracted, and PRDATA is not updated.
REQ-031 A setup phase arriving in ACK SHALL be ignored; the FSM accepts a new transfer only in IDLE (back-to-back transfers cost one IDLE cycle).
REQ-032 rf_wr_en and rf_rd_en SHALL never be high in the same cycle.
REQ-033 rf_addr and rf_data_in SHALL hold their last values outside strobe cycles.

Reset
REQ-034 reset=1 SHALL asynchronously force state IDLE, counter 0, and PRDATA, PREADY, PSLVERR, rf_wr_en, rf_rd_en, rf_addr and rf_data_in to 0.
REQ-035 Reset mid-transfer SHALL abandon the transfer with no PREADY; the first setup phase after reset release is accepted normally.

Structure
REQ-036 Package apb_regfile_pkg SHALL hold the state enum, the register count (16), the data width (8) and the error-decode constants.
REQ-037 The design SHALL be a single module with no sub-module; the 16x8 register file is instantiated beside it by the integrating top.

Verification
REQ-038 Write PADDR=0x0C, PWDATA=0x000000A5 -> rf_wr_en one cycle, rf_addr=3, rf_data_in=0xA5; PREADY in the 2nd cycle; PSLVERR=0.
REQ-039 Write 0x5A to reg 7, then read PADDR=0x1C (register-file model, RD_LATENCY=2) -> PRDATA=0x0000005A; PREADY in the 4th cycle after the setup edge.
REQ-040 Read PADDR=0x41 and write PADDR=0x80 -> PSLVERR=1 with PREADY, no rf strobe, PRDATA unchanged.
REQ-041 Drop PSEL in RDWAIT -> FSM returns to IDLE, no PREADY; the next read completes correctly.
REQ-042 Assert reset during WR and during RDWAIT -> all outputs 0 immediately; a post-reset write/read of reg 15 (0xFF) passes.
REQ-043 Run back-to-back write/read to all 16 registers with RD_LATENCY=1 and 3 -> all readback values match; rf_wr_en and rf_rd_en are never high together.
